// File: rtl/ctrl_pipeline_chain.sv
// Control-word pipeline from ID through NUM_STAGES stage registers.
// Handles load-use bubbles, branch flush and a global freeze, drives the
// PC / IF-ID enables and keeps saturating stall and flush counters.

// One stage register: control word, destination register, valid bit.
module cpc_stage #(
  parameter int CTRL_W  = 8,
  parameter int RADDR_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [CTRL_W-1:0]  ctrl_d,
  input  logic [RADDR_W-1:0] rd_d,
  input  logic               vld_d,
  output logic [CTRL_W-1:0]  ctrl_q,
  output logic [RADDR_W-1:0] rd_q,
  output logic               vld_q
);
  // stage register; hold/shift/bubble selection happens in the parent
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q <= '0;
      rd_q   <= '0;
      vld_q  <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      rd_q   <= rd_d;
      vld_q  <= vld_d;
    end
  end
endmodule

module ctrl_pipeline_chain #(
  parameter int NUM_STAGES   = 3,
  parameter int CTRL_W       = 8,
  parameter int RADDR_W      = 4,
  parameter int REGWRITE_BIT = 7,
  parameter int MEMTOREG_BIT = 5,
  parameter int LOAD_LAT     = 1,
  parameter int BRANCH_STAGE = 1,
  parameter int STAT_W       = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [CTRL_W-1:0]             id_ctrl_in,
  input  logic                          id_valid_in,
  input  logic [RADDR_W-1:0]            id_rd_in,
  input  logic [RADDR_W-1:0]            id_rn_in,
  input  logic [RADDR_W-1:0]            id_rm_in,
  input  logic                          id_uses_rn,
  input  logic                          id_uses_rm,
  input  logic                          ext_stall,
  input  logic                          flush_req,
  output logic [NUM_STAGES*CTRL_W-1:0]  stage_ctrl_out,
  output logic [NUM_STAGES-1:0]         stage_valid_out,
  output logic [NUM_STAGES*RADDR_W-1:0] stage_rd_out,
  output logic                          pc_enable,
  output logic                          if_id_enable,
  output logic                          if_id_flush,
  output logic                          load_use_stall,
  output logic [STAT_W-1:0]             stall_count,
  output logic [STAT_W-1:0]             flush_count
);
  logic [NUM_STAGES-1:0][CTRL_W-1:0]  ctrl_q, ctrl_d;
  logic [NUM_STAGES-1:0][RADDR_W-1:0] rd_q, rd_d;
  logic [NUM_STAGES-1:0]              vld_q, vld_d;
  logic [STAT_W-1:0]                  stall_cnt_q, stall_cnt_d;
  logic [STAT_W-1:0]                  flush_cnt_q, flush_cnt_d;
  logic                               hazard, do_flush, do_stall;

  genvar g;
  generate
    for (g = 0; g < NUM_STAGES; g++) begin : g_stg
      cpc_stage #(.CTRL_W(CTRL_W), .RADDR_W(RADDR_W)) u_stg (
        .clk     (clk),
        .reset_n (reset_n),
        .ctrl_d  (ctrl_d[g]),
        .rd_d    (rd_d[g]),
        .vld_d   (vld_d[g]),
        .ctrl_q  (ctrl_q[g]),
        .rd_q    (rd_q[g]),
        .vld_q   (vld_q[g])
      );
      assign stage_ctrl_out[g*CTRL_W +: CTRL_W]   = ctrl_q[g];
      assign stage_rd_out[g*RADDR_W +: RADDR_W]   = rd_q[g];
      assign stage_valid_out[g]                   = vld_q[g];
    end
  endgenerate

  // raw load-use detect against the stages that cannot yet forward a load;
  // reported even when freeze/flush overrides it, the mode signals gate its effect
  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < LOAD_LAT; k++) begin
      if (vld_q[k] && ctrl_q[k][MEMTOREG_BIT] && ctrl_q[k][REGWRITE_BIT] &&
          ((id_uses_rn && (rd_q[k] == id_rn_in)) ||
           (id_uses_rm && (rd_q[k] == id_rm_in))))
        hazard = 1'b1;
    end
    hazard   = hazard & id_valid_in;
    do_flush = !ext_stall && flush_req;
    do_stall = !ext_stall && !flush_req && hazard;
  end

  // next stage contents and counters: freeze > flush > load-use > run
  always_comb begin
    ctrl_d      = ctrl_q;
    rd_d        = rd_q;
    vld_d       = vld_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!ext_stall) begin
      for (int k = NUM_STAGES - 1; k >= 1; k--) begin
        if (do_flush && k <= BRANCH_STAGE) begin
          ctrl_d[k] = '0;
          rd_d[k]   = '0;
          vld_d[k]  = 1'b0;
        end else begin
          ctrl_d[k] = ctrl_q[k-1];
          rd_d[k]   = rd_q[k-1];
          vld_d[k]  = vld_q[k-1];
        end
      end
      if (do_flush || do_stall || !id_valid_in) begin
        ctrl_d[0] = '0;
        rd_d[0]   = '0;
        vld_d[0]  = 1'b0;
      end else begin
        ctrl_d[0] = id_ctrl_in;
        rd_d[0]   = id_rd_in;
        vld_d[0]  = 1'b1;
      end
      if (do_flush && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + STAT_W'(1);
      if (do_stall && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + STAT_W'(1);
    end
  end

  // saturating statistics counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // front-end enables: freeze and load-use both hold PC and IF/ID
  always_comb begin
    pc_enable      = !ext_stall && !do_stall;
    if_id_enable   = !ext_stall && !do_stall;
    if_id_flush    = do_flush;
    load_use_stall = hazard;
    stall_count    = stall_cnt_q;
    flush_count    = flush_cnt_q;
  end
endmodule

// File: tb/tb_ctrl_pipeline_chain.sv
// Bench for ctrl_pipeline_chain: a list-style pipeline model checked every
// cycle, plus literal checkpoints. A second instance with 2-bit counters
// exercises saturation in a few cycles.
module tb_ctrl_pipeline_chain;
  localparam int NS = 3, CW = 8, RW = 4, BS = 1, LL = 1;

  logic clk = 1'b0, reset_n = 1'b0;
  logic [CW-1:0] id_ctrl_in = '0;
  logic id_valid_in = 1'b0, id_uses_rn = 1'b0, id_uses_rm = 1'b0;
  logic [RW-1:0] id_rd_in = '0, id_rn_in = '0, id_rm_in = '0;
  logic ext_stall = 1'b0, flush_req = 1'b0;

  logic [NS*CW-1:0] stage_ctrl_out, s_ctrl;
  logic [NS-1:0]    stage_valid_out, s_vld;
  logic [NS*RW-1:0] stage_rd_out, s_rd;
  logic pc_enable, if_id_enable, if_id_flush, load_use_stall;
  logic s_pc, s_ifen, s_iffl, s_lus;
  logic [15:0] stall_count, flush_count;
  logic [1:0]  s_stall, s_flush;

  int total = 0, bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  ctrl_pipeline_chain dut (
    .clk(clk), .reset_n(reset_n), .id_ctrl_in(id_ctrl_in), .id_valid_in(id_valid_in),
    .id_rd_in(id_rd_in), .id_rn_in(id_rn_in), .id_rm_in(id_rm_in),
    .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm), .ext_stall(ext_stall),
    .flush_req(flush_req), .stage_ctrl_out(stage_ctrl_out),
    .stage_valid_out(stage_valid_out), .stage_rd_out(stage_rd_out),
    .pc_enable(pc_enable), .if_id_enable(if_id_enable), .if_id_flush(if_id_flush),
    .load_use_stall(load_use_stall), .stall_count(stall_count), .flush_count(flush_count));

  ctrl_pipeline_chain #(.STAT_W(2)) dut_s (
    .clk(clk), .reset_n(reset_n), .id_ctrl_in(id_ctrl_in), .id_valid_in(id_valid_in),
    .id_rd_in(id_rd_in), .id_rn_in(id_rn_in), .id_rm_in(id_rm_in),
    .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm), .ext_stall(ext_stall),
    .flush_req(flush_req), .stage_ctrl_out(s_ctrl), .stage_valid_out(s_vld),
    .stage_rd_out(s_rd), .pc_enable(s_pc), .if_id_enable(s_ifen), .if_id_flush(s_iffl),
    .load_use_stall(s_lus), .stall_count(s_stall), .flush_count(s_flush));

  typedef struct packed { logic [CW-1:0] c; logic [RW-1:0] r; logic v; } ent_t;
  ent_t m [NS];
  int m_sc, m_fc, m_ss, m_fs;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // instruction in stage 0 is a load writing the register ID reads
  function automatic bit m_hazard();
    bit h = 0;
    for (int k = 0; k < LL; k++)
      if (m[k].v && m[k].c[5] && m[k].c[7] &&
          ((id_uses_rn && m[k].r == id_rn_in) || (id_uses_rm && m[k].r == id_rm_in)))
        h = 1;
    return h && id_valid_in;
  endfunction

  // 0 run, 1 load-use, 2 flush, 3 freeze
  function automatic int m_mode();
    if (ext_stall) return 3;
    if (flush_req) return 2;
    if (m_hazard()) return 1;
    return 0;
  endfunction

  // model: pipeline as a list that moves one slot per accepted edge
  always @(posedge clk or negedge reset_n) begin
    ent_t n [NS];
    int md;
    if (!reset_n) begin
      for (int k = 0; k < NS; k++) m[k] <= '0;
      m_sc <= 0; m_fc <= 0; m_ss <= 0; m_fs <= 0;
    end else begin
      md = m_mode();
      for (int k = 0; k < NS; k++) n[k] = m[k];
      if (md != 3) begin
        for (int k = NS - 1; k >= 1; k--) n[k] = m[k-1];
        n[0] = (md == 0 && id_valid_in) ? ent_t'{id_ctrl_in, id_rd_in, 1'b1} : ent_t'('0);
        if (md == 2) for (int k = 0; k <= BS; k++) n[k] = '0;
      end
      for (int k = 0; k < NS; k++) m[k] <= n[k];
      if (md == 1) begin
        m_sc <= (m_sc == 65535) ? m_sc : m_sc + 1;
        m_ss <= (m_ss == 3) ? m_ss : m_ss + 1;
      end
      if (md == 2) begin
        m_fc <= (m_fc == 65535) ? m_fc : m_fc + 1;
        m_fs <= (m_fs == 3) ? m_fs : m_fs + 1;
      end
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    logic [NS*CW-1:0] ec;
    logic [NS*RW-1:0] er;
    logic [NS-1:0] ev;
    int md;
    if (chk_en) begin
      for (int k = 0; k < NS; k++) begin
        ec[k*CW +: CW] = m[k].c;
        er[k*RW +: RW] = m[k].r;
        ev[k] = m[k].v;
      end
      md = m_mode();
      chk("ctrl", 32'(stage_ctrl_out), 32'(ec));
      chk("rd", 32'(stage_rd_out), 32'(er));
      chk("valid", 32'(stage_valid_out), 32'(ev));
      chk("pc_en", 32'(pc_enable), 32'(md == 0 || md == 2));
      chk("ifid_en", 32'(if_id_enable), 32'(md == 0 || md == 2));
      chk("ifid_fl", 32'(if_id_flush), 32'(md == 2));
      chk("lus", 32'(load_use_stall), 32'(m_hazard()));
      chk("stall_cnt", 32'(stall_count), 32'(m_sc));
      chk("flush_cnt", 32'(flush_count), 32'(m_fc));
      chk("s_stall_cnt", 32'(s_stall), 32'(m_ss));
      chk("s_flush_cnt", 32'(s_flush), 32'(m_fs));
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_id(input logic [7:0] c, input logic [3:0] rd, input logic [3:0] rn,
                        input logic urn, input logic v);
    id_ctrl_in = c; id_rd_in = rd; id_rn_in = rn; id_rm_in = 4'hF;
    id_uses_rn = urn; id_uses_rm = 1'b0; id_valid_in = v;
  endtask

  initial begin
    // reset state
    step(); step();
    chk_en = 1'b1;
    chk("rst_ctrl", 32'(stage_ctrl_out), 0);
    chk("rst_pc_en", 32'(pc_enable), 1);
    #5 reset_n = 1'b1;
    step();

    // plain stream
    set_id(8'h81, 4'd1, 4'd0, 1'b0, 1'b1); step();
    chk("s2_e1_ctrl", 32'(stage_ctrl_out), 32'h000081);
    chk("s2_e1_vld", 32'(stage_valid_out), 32'b001);
    set_id(8'h82, 4'd2, 4'd0, 1'b0, 1'b1); step();
    chk("s2_e2_ctrl", 32'(stage_ctrl_out), 32'h008182);
    chk("s2_e2_vld", 32'(stage_valid_out), 32'b011);
    set_id(8'h83, 4'd3, 4'd0, 1'b0, 1'b1); step();
    chk("s2_e3_ctrl", 32'(stage_ctrl_out), 32'h818283);
    chk("s2_e3_vld", 32'(stage_valid_out), 32'b111);
    chk("s2_e3_rd", 32'(stage_rd_out), 32'h123);
    set_id(8'h00, 4'd0, 4'd0, 1'b0, 1'b0); step(); step(); step();

    // load-use: one stall cycle, then the user enters stage 0
    set_id(8'hA0, 4'd2, 4'd0, 1'b0, 1'b1); step();
    set_id(8'h84, 4'd5, 4'd2, 1'b1, 1'b1); #1;
    chk("s3_lus", 32'(load_use_stall), 1);
    chk("s3_pc_en", 32'(pc_enable), 0);
    step();
    chk("s3_stall_cnt", 32'(stall_count), 1);
    chk("s3_bubble", 32'(stage_ctrl_out), 32'h00A000);
    chk("s3_vld", 32'(stage_valid_out), 32'b010);
    chk("s3_lus_clear", 32'(load_use_stall), 0);
    step();
    chk("s3_enter", 32'(stage_ctrl_out), 32'hA00084);
    set_id(8'h00, 4'd0, 4'd0, 1'b0, 1'b0); step(); step(); step();

    // flush with a live load-use hazard
    set_id(8'h90, 4'd0, 4'd0, 1'b0, 1'b1); step();
    set_id(8'hA0, 4'd3, 4'd0, 1'b0, 1'b1); step();
    set_id(8'h85, 4'd6, 4'd3, 1'b1, 1'b1); flush_req = 1'b1; #1;
    chk("s4_ifid_fl", 32'(if_id_flush), 1);
    chk("s4_pc_en", 32'(pc_enable), 1);
    step();
    flush_req = 1'b0;
    chk("s4_ctrl", 32'(stage_ctrl_out), 32'h900000);
    chk("s4_vld", 32'(stage_valid_out), 32'b100);
    chk("s4_stall_cnt", 32'(stall_count), 1);
    chk("s4_flush_cnt", 32'(flush_count), 1);

    // freeze with pending flush
    set_id(8'h86, 4'd7, 4'd0, 1'b0, 1'b1); step();
    set_id(8'h87, 4'd8, 4'd0, 1'b0, 1'b1); step();
    set_id(8'h88, 4'd9, 4'd0, 1'b0, 1'b1);
    ext_stall = 1'b1; flush_req = 1'b1; #1;
    chk("s5_pc_en", 32'(pc_enable), 0);
    chk("s5_ifid_fl", 32'(if_id_flush), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("s5_hold_ctrl", 32'(stage_ctrl_out), 32'h008687);
      chk("s5_hold_fc", 32'(flush_count), 1);
    end
    ext_stall = 1'b0; step();
    flush_req = 1'b0;
    chk("s5_flush_ctrl", 32'(stage_ctrl_out), 32'h860000);
    chk("s5_flush_fc", 32'(flush_count), 2);
    set_id(8'h00, 4'd0, 4'd0, 1'b0, 1'b0); step(); step();

    // saturation: small counter from 1 to 2, then 3 more hazards hold at 3
    for (int i = 0; i < 4; i++) begin
      set_id(8'hA0, 4'(10 + i), 4'd0, 1'b0, 1'b1); step();
      set_id(8'h84, 4'd1, 4'(10 + i), 1'b1, 1'b1); step(); step();
      if (i == 0) chk("s6_small_2", 32'(s_stall), 2);
    end
    chk("s6_small_sat", 32'(s_stall), 3);
    chk("s6_main_cnt", 32'(stall_count), 5);

    // asynchronous reset mid-cycle
    #2 reset_n = 1'b0; #1;
    chk("s1_ctrl", 32'(stage_ctrl_out), 0);
    chk("s1_rd", 32'(stage_rd_out), 0);
    chk("s1_vld", 32'(stage_valid_out), 0);
    chk("s1_sc", 32'(stall_count), 0);
    chk("s1_fc", 32'(flush_count), 0);
    chk("s1_pc_en", 32'(pc_enable), 1);
    chk("s1_ifid_en", 32'(if_id_enable), 1);
    chk("s1_ifid_fl", 32'(if_id_flush), 0);
    step(); step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
